// File: rtl/weight_stream_ctrl_if.sv
// Bus bundle for weight_stream_ctrl: loader AXI-Stream in, weight AXI-Stream out,
// and the weight RAM write/read ports. master = controller side, slave = environment side.
interface weight_stream_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tlast;

    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        input  m_axis_tready,
        output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
        input  mem_rdata
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        output m_axis_tready,
        input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
        output mem_rdata
    );
endinterface

// File: rtl/weight_stream_ctrl.sv
// Weight store controller: arbitrates the weight RAM between a host loader (write a full set)
// and the neuron datapath (stream the full set back out through a 2-entry skid buffer).
module weight_stream_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NO_OF_WEIGHT = 784,
    parameter int unsigned ADDR_WIDTH   = $clog2(NO_OF_WEIGHT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start_i,
    input  logic                stream_start_i,
    weight_stream_ctrl_if.master bus,
    output logic                busy_o,
    output logic                weights_valid_o,
    output logic                load_done_o,
    output logic                stream_done_o,
    output logic                cmd_err_o
);
    localparam int unsigned      CNT_W    = $clog2(NO_OF_WEIGHT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NO_OF_WEIGHT - 1);
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(NO_OF_WEIGHT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  wv_q, wv_d;
    logic                  load_done_q, load_done_d;
    logic                  stream_done_q, stream_done_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  buf_wptr_q, buf_wptr_d;
    logic                  buf_rptr_q, buf_rptr_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;

    logic                  pop;
    logic                  push;
    logic                  rd_en;
    logic [2:0]            occ_next;

    // Buffer head drives the output stream; out_cnt_q is the index of the head beat.
    assign bus.m_axis_tvalid = (buf_cnt_q != 2'd0);
    assign bus.m_axis_tdata  = buf_q[buf_rptr_q];
    assign bus.m_axis_tlast  = (buf_cnt_q != 2'd0) && (out_cnt_q == LAST_IDX);

    assign busy_o          = (state_q != IDLE) || (buf_cnt_q != 2'd0);
    assign weights_valid_o = wv_q;
    assign load_done_o     = load_done_q;
    assign stream_done_o   = stream_done_q;
    assign cmd_err_o       = cmd_err_q;

    // Next-state, RAM port and buffer control.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        out_cnt_d     = out_cnt_q;
        wv_d          = wv_q;
        load_done_d   = 1'b0;
        stream_done_d = 1'b0;
        cmd_err_d     = 1'b0;
        buf_d         = buf_q;
        buf_wptr_d    = buf_wptr_q;
        buf_rptr_d    = buf_rptr_q;
        rd_en         = 1'b0;

        bus.s_axis_tready = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_waddr     = ADDR_WIDTH'(wr_cnt_q);
        bus.mem_wdata     = bus.s_axis_tdata;
        bus.mem_re        = 1'b0;
        bus.mem_raddr     = ADDR_WIDTH'(rd_cnt_q);

        pop      = (buf_cnt_q != 2'd0) && bus.m_axis_tready;
        push     = inflight_q;
        occ_next = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);

        unique case (state_q)
            IDLE: begin
                if (load_start_i) begin
                    state_d  = LOAD;
                    wv_d     = 1'b0;
                    wr_cnt_d = '0;
                end else if (stream_start_i) begin
                    if (wv_q) begin
                        state_d   = STREAM;
                        rd_cnt_d  = '0;
                        out_cnt_d = '0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid) begin
                    bus.mem_we = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        if (bus.s_axis_tlast) begin
                            load_done_d = 1'b1;
                            wv_d        = 1'b1;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else if (bus.s_axis_tlast) begin
                        // Short set: leave weights_valid low so no partial set is ever streamed.
                        state_d   = IDLE;
                        cmd_err_d = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    end
                end
            end

            STREAM: begin
                // Never issue a read that could not land in the buffer.
                rd_en      = (rd_cnt_q < N_CNT) && (occ_next < 3'd2);
                bus.mem_re = rd_en;
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == LAST_IDX) begin
                        stream_done_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Keep the RAM and loader quiet while reset is held.
        if (reset) begin
            bus.s_axis_tready = 1'b0;
            bus.mem_we        = 1'b0;
            bus.mem_re        = 1'b0;
            rd_en             = 1'b0;
        end

        inflight_d = rd_en;

        if (push) begin
            buf_d[buf_wptr_q] = bus.mem_rdata;
            buf_wptr_d        = ~buf_wptr_q;
        end
        if (pop) begin
            buf_rptr_d = ~buf_rptr_q;
        end
        buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            out_cnt_q     <= '0;
            wv_q          <= 1'b0;
            load_done_q   <= 1'b0;
            stream_done_q <= 1'b0;
            cmd_err_q     <= 1'b0;
            inflight_q    <= 1'b0;
            buf_q[0]      <= '0;
            buf_q[1]      <= '0;
            buf_wptr_q    <= 1'b0;
            buf_rptr_q    <= 1'b0;
            buf_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            out_cnt_q     <= out_cnt_d;
            wv_q          <= wv_d;
            load_done_q   <= load_done_d;
            stream_done_q <= stream_done_d;
            cmd_err_q     <= cmd_err_d;
            inflight_q    <= inflight_d;
            buf_q         <= buf_d;
            buf_wptr_q    <= buf_wptr_d;
            buf_rptr_q    <= buf_rptr_d;
            buf_cnt_q     <= buf_cnt_d;
        end
    end

endmodule
